// File: rtl/spr_pkg.sv
// Shared definitions for the single-port RAM burst controller.
// Contents:
//   DW_DEF  - default RAM data width
//   AW_DEF  - default RAM address width (2**AW_DEF locations)
//   state_t - controller FSM state encoding
package spr_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        TURN  = 2'd3
    } state_t;

endpackage

// File: rtl/spr_bus_drv.sv
// Tristate driver for the shared RAM data bus.
// Ports:
//   oe   - drive enable; pad floats when low
//   dout - value placed on the pad while oe is high
//   pad  - bidirectional bus
module spr_bus_drv
    import spr_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          oe,
    input  logic [DW-1:0] dout,
    inout  wire  [DW-1:0] pad
);

    assign pad = oe ? dout : {DW{1'bz}};

endmodule

// File: rtl/spr_ctrl.sv
// Burst controller for a single-port RAM with a bidirectional data bus.
// A request (start address, beat count minus one, direction) is accepted in
// IDLE; the burst then runs one beat per cycle with the address wrapping
// modulo 2**AW, and one TURN cycle separates every burst from the next so the
// bus is never driven by both sides across a direction change.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the rising clock edge. req_* and wd_* follow this rule; rd_* has no
// ready and every rd_valid cycle is a delivered beat.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid/req_ready - burst request handshake (req_wr, req_addr, req_len)
//   wd_valid/wd_ready   - write-data handshake (wd_data)
//   rd_valid/rd_data    - read beats, one cycle after the RAM beat; rd_last on final
//   busy                - high whenever the FSM is not in IDLE
//   mem_wr/mem_en       - RAM write strobe / read enable (never both high)
//   mem_add, mem_d      - RAM address and bidirectional data
//   state_dbg           - current FSM state
module spr_ctrl
    import spr_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [DW-1:0] wd_data,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          busy,
    output logic          mem_wr,
    output logic          mem_en,
    output logic [AW-1:0] mem_add,
    inout  wire  [DW-1:0] mem_d,
    output state_t        state_dbg
);

    state_t        state;
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    logic [AW-1:0] cnt;
    logic          last_beat;

    assign last_beat = (cnt == len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            len      <= '0;
            cnt      <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr  <= req_addr;
                        len   <= req_len;
                        cnt   <= '0;
                        state <= req_wr ? WRITE : READ;
                    end
                end
                WRITE: begin
                    // Without a data beat the address and count simply hold.
                    if (wd_valid) begin
                        addr <= addr + 1'b1;
                        cnt  <= cnt + 1'b1;
                        if (last_beat) state <= TURN;
                    end
                end
                READ: begin
                    // The RAM drives mem_d during the beat; capture it at the
                    // edge that ends the beat so it appears one cycle later.
                    rd_data  <= mem_d;
                    rd_valid <= 1'b1;
                    rd_last  <= last_beat;
                    addr     <= addr + 1'b1;
                    cnt      <= cnt + 1'b1;
                    if (last_beat) state <= TURN;
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // req_ready is gated by rst so it is low for the whole reset pulse even
    // though the state register already reads IDLE.
    assign req_ready = (state == IDLE) && !rst;
    assign wd_ready  = (state == WRITE);
    assign busy      = (state != IDLE);
    // The write strobe follows the data handshake in the same cycle.
    assign mem_wr    = (state == WRITE) && wd_valid;
    assign mem_en    = (state == READ);
    assign mem_add   = addr;
    assign state_dbg = state;

    spr_bus_drv #(.DW(DW)) u_bus_drv (
        .oe   (mem_wr && !mem_en),
        .dout (wd_data),
        .pad  (mem_d)
    );

endmodule

// File: tb/tb_spr_ctrl.sv
module tb_spr_ctrl;
    import spr_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [AW-1:0] req_len;
    logic          wd_valid;
    logic          wd_ready;
    logic [DW-1:0] wd_data;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          mem_wr;
    logic          mem_en;
    logic [AW-1:0] mem_add;
    wire  [DW-1:0] mem_d;
    state_t        state_dbg;

    logic [DW-1:0] ram     [16];
    logic [DW-1:0] exp_mem [16];
    logic [DW-1:0] wbuf    [16];
    logic          probe_en;
    logic [DW-1:0] probe_val;

    int n_cmp;
    int n_err;

    spr_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .mem_wr    (mem_wr),
        .mem_en    (mem_en),
        .mem_add   (mem_add),
        .mem_d     (mem_d),
        .state_dbg (state_dbg)
    );

    // RAM model: asynchronous read while enabled, write on the clock edge.
    // When the DUT must float the bus, the probe drives a known pattern so a
    // stray DUT driver shows up as a corrupted value.
    assign mem_d = (mem_en && !mem_wr) ? ram[mem_add] :
                   (probe_en ? probe_val : {DW{1'bz}});

    always @(posedge clk) begin
        if (mem_wr) ram[mem_add] <= mem_d;
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Strobe exclusivity in every cycle of every scenario.
    always @(negedge clk) begin
        n_cmp++;
        if (mem_wr && mem_en) begin
            n_err++;
            $display("FAIL strobe_excl: mem_wr=%0b mem_en=%0b required not both 1", mem_wr, mem_en);
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        wd_valid = 1'b0; wd_data = '0; probe_en = 1'b1; probe_val = 8'h5A;
        #1 rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b required 0", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++; if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin n_err++; $display("FAIL rst_rd: got v=%b l=%b required 0 0", rd_valid, rd_last); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data: got %h required 00", rd_data); end
        n_cmp++; if (mem_add !== 4'h0) begin n_err++; $display("FAIL rst_mem_add: got %h required 0", mem_add); end
        n_cmp++; if (mem_d !== 8'h5A) begin n_err++; $display("FAIL rst_mem_d_float: got %h required 5a", mem_d); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b required 1", req_ready); end
        n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL rst_state: got %0d required %0d", state_dbg, IDLE); end
        @(posedge clk); #1;
        probe_en = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                               input int stall_at, input int stall_n, input bit hold);
        logic [AW-1:0] ea;
        int beats;
        beats = int'(l) + 1;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_len = l;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL wr_accept_ready: got %b required 1", req_ready); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL wr_idle_rd_valid: got %b required 0", rd_valid); end
        @(posedge clk); #1;
        if (hold) begin
            req_wr = 1'b0;  // keep offering: a read of the same range
        end else begin
            req_valid = 1'b0;
        end
        for (int i = 0; i < beats; i++) begin
            ea = a + AW'(i);
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    wd_valid = 1'b0; wd_data = 8'hA5; probe_en = 1'b1; probe_val = 8'h5A;
                    @(negedge clk);
                    n_cmp++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL stall_mem_wr: got %b required 0", mem_wr); end
                    n_cmp++; if (mem_d !== 8'h5A) begin n_err++; $display("FAIL stall_mem_d_float: got %h required 5a", mem_d); end
                    n_cmp++; if (mem_add !== ea) begin n_err++; $display("FAIL stall_addr_hold: got %h required %h", mem_add, ea); end
                    n_cmp++; if (wd_ready !== 1'b1) begin n_err++; $display("FAIL stall_wd_ready: got %b required 1", wd_ready); end
                    @(posedge clk); #1;
                    probe_en = 1'b0;
                end
            end
            wd_valid = 1'b1; wd_data = wbuf[i];
            @(negedge clk);
            n_cmp++; if (wd_ready !== 1'b1) begin n_err++; $display("FAIL wr_wd_ready beat %0d: got %b required 1", i, wd_ready); end
            n_cmp++; if (mem_wr !== 1'b1 || mem_en !== 1'b0) begin n_err++; $display("FAIL wr_strobes beat %0d: got wr=%b en=%b required 1 0", i, mem_wr, mem_en); end
            n_cmp++; if (mem_add !== ea) begin n_err++; $display("FAIL wr_mem_add beat %0d: got %h required %h", i, mem_add, ea); end
            n_cmp++; if (mem_d !== wbuf[i]) begin n_err++; $display("FAIL wr_mem_d beat %0d: got %h required %h", i, mem_d, wbuf[i]); end
            if (hold) begin
                n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL held_req_ready beat %0d: got %b required 0", i, req_ready); end
            end
            exp_mem[ea] = wbuf[i];
            @(posedge clk); #1;
        end
        wd_valid = 1'b0; probe_en = 1'b1; probe_val = 8'hC3;
        @(negedge clk);
        n_cmp++; if (state_dbg !== TURN) begin n_err++; $display("FAIL wr_turn_state: got %0d required %0d", state_dbg, TURN); end
        n_cmp++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_err++; $display("FAIL wr_turn_busy: got busy=%b ready=%b required 1 0", busy, req_ready); end
        n_cmp++; if (mem_wr !== 1'b0 || mem_en !== 1'b0 || wd_ready !== 1'b0) begin n_err++; $display("FAIL wr_turn_strobes: got wr=%b en=%b wdr=%b required 0 0 0", mem_wr, mem_en, wd_ready); end
        n_cmp++; if (mem_d !== 8'hC3) begin n_err++; $display("FAIL wr_turn_mem_d_float: got %h required c3", mem_d); end
        @(posedge clk); #1;
        probe_en = 1'b0;
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input logic [AW-1:0] l);
        logic [AW-1:0] ea;
        logic [AW-1:0] pa;
        int beats;
        beats = int'(l) + 1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = a; req_len = l;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rd_accept_ready: got %b required 1", req_ready); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rd_idle_rd_valid: got %b required 0", rd_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < beats; k++) begin
            ea = a + AW'(k);
            pa = ea - 1'b1;
            @(negedge clk);
            n_cmp++; if (mem_en !== 1'b1 || mem_wr !== 1'b0) begin n_err++; $display("FAIL rd_strobes beat %0d: got en=%b wr=%b required 1 0", k, mem_en, mem_wr); end
            n_cmp++; if (mem_add !== ea) begin n_err++; $display("FAIL rd_mem_add beat %0d: got %h required %h", k, mem_add, ea); end
            n_cmp++; if (rd_valid !== (k > 0)) begin n_err++; $display("FAIL rd_valid beat %0d: got %b required %b", k, rd_valid, (k > 0)); end
            if (k > 0) begin
                n_cmp++; if (rd_data !== exp_mem[pa] || rd_last !== 1'b0) begin n_err++; $display("FAIL rd_data beat %0d: got %h last=%b required %h last=0", k - 1, rd_data, rd_last, exp_mem[pa]); end
            end
            @(posedge clk); #1;
        end
        ea = a + l;
        probe_en = 1'b1; probe_val = 8'h3C;
        @(negedge clk);
        n_cmp++; if (rd_valid !== 1'b1 || rd_last !== 1'b1) begin n_err++; $display("FAIL rd_last_flags: got v=%b l=%b required 1 1", rd_valid, rd_last); end
        n_cmp++; if (rd_data !== exp_mem[ea]) begin n_err++; $display("FAIL rd_last_data: got %h required %h", rd_data, exp_mem[ea]); end
        n_cmp++; if (state_dbg !== TURN || mem_en !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rd_turn: got st=%0d en=%b busy=%b required %0d 0 1", state_dbg, mem_en, busy, TURN); end
        n_cmp++; if (mem_d !== 8'h3C) begin n_err++; $display("FAIL rd_turn_mem_d_float: got %h required 3c", mem_d); end
        @(posedge clk); #1;
        probe_en = 1'b0;
    endtask

    task automatic test_full_sweep();
        for (int i = 0; i < 16; i++) wbuf[i] = 8'(i);
        write_burst(4'd0, 4'd15, -1, 0, 1'b0);
        read_burst(4'd0, 4'd15);
    endtask

    task automatic test_wrap();
        wbuf[0] = 8'hA0; wbuf[1] = 8'hA1; wbuf[2] = 8'hA2; wbuf[3] = 8'hA3;
        write_burst(4'd14, 4'd3, -1, 0, 1'b0);
        read_burst(4'd14, 4'd3);
    endtask

    task automatic test_stall();
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        write_burst(4'd5, 4'd3, 2, 3, 1'b0);
        read_burst(4'd5, 4'd3);
    endtask

    task automatic test_back_to_back_held_req();
        wbuf[0] = 8'h66; wbuf[1] = 8'h77;
        write_burst(4'd4, 4'd1, -1, 0, 1'b1);
        read_burst(4'd4, 4'd1);
    endtask

    task automatic test_reset_mid_read();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd0; req_len = 4'd7;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rmr_accept_ready: got %b required 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_en !== 1'b1 || mem_add !== 4'd0) begin n_err++; $display("FAIL rmr_beat0: got en=%b add=%h required 1 0", mem_en, mem_add); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== exp_mem[0]) begin n_err++; $display("FAIL rmr_beat0_data: got v=%b d=%h required 1 %h", rd_valid, rd_data, exp_mem[0]); end
        @(posedge clk); #1;
        // Beat 2 is on the bus now; reset mid-cycle.
        probe_en = 1'b1; probe_val = 8'h96;
        rst = 1'b1;
        #1;
        n_cmp++; if (state_dbg !== IDLE || busy !== 1'b0) begin n_err++; $display("FAIL rmr_async_state: got st=%0d busy=%b required %0d 0", state_dbg, busy, IDLE); end
        n_cmp++; if (req_ready !== 1'b0 || wd_ready !== 1'b0) begin n_err++; $display("FAIL rmr_async_ready: got req=%b wd=%b required 0 0", req_ready, wd_ready); end
        n_cmp++; if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 8'h00) begin n_err++; $display("FAIL rmr_async_rd: got v=%b l=%b d=%h required 0 0 00", rd_valid, rd_last, rd_data); end
        n_cmp++; if (mem_wr !== 1'b0 || mem_en !== 1'b0 || mem_add !== 4'd0) begin n_err++; $display("FAIL rmr_async_mem: got wr=%b en=%b add=%h required 0 0 0", mem_wr, mem_en, mem_add); end
        n_cmp++; if (mem_d !== 8'h96) begin n_err++; $display("FAIL rmr_async_mem_d_float: got %h required 96", mem_d); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rmr_release_ready: got %b required 1", req_ready); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            n_cmp++; if (rd_valid !== 1'b0 || mem_en !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmr_no_beats cyc %0d: got v=%b en=%b busy=%b required 0 0 0", c, rd_valid, mem_en, busy); end
        end
        @(posedge clk); #1;
        probe_en = 1'b0;
        read_burst(4'd0, 4'd7);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 16; i++) begin
            ram[i] = '0; exp_mem[i] = '0; wbuf[i] = '0;
        end
        test_reset();
        test_full_sweep();
        test_wrap();
        test_stall();
        test_back_to_back_held_req();
        test_reset_mid_read();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spr_ctrl.md
SPR_CTRL -- requirements
Module: spr_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, data width of the attached single-port RAM.
REQ-002 SHALL have parameter AW, default 4, address width (16 locations).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, burst request offered.
REQ-006 SHALL have port req_ready, output, 1, request accepted when req_valid and req_ready are both high.
REQ-007 SHALL have port req_wr, input, 1, 1 = write burst, 0 = read burst.
REQ-008 SHALL have port req_addr, input, AW, burst start address.
REQ-009 SHALL have port req_len, input, AW, beat count minus 1.
REQ-010 SHALL have port wd_valid, input, 1, write-data beat offered.
REQ-011 SHALL have port wd_ready, output, 1, write beat consumed when wd_valid and wd_ready are both high.
REQ-012 SHALL have port wd_data, input, DW, write-data beat.
REQ-013 SHALL have port rd_valid, output, 1, read beat valid for one cycle; no backpressure.
REQ-014 SHALL have port rd_data, output, DW, read beat.
REQ-015 SHALL have port rd_last, output, 1, marks final read beat.
REQ-016 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-017 SHALL have port mem_wr, output, 1, RAM write strobe.
REQ-018 SHALL have port mem_en, output, 1, RAM read enable.
REQ-019 SHALL have port mem_add, output, AW, RAM address.
REQ-020 SHALL have port mem_d, inout, DW, bidirectional RAM data; driven only when mem_wr=1 and mem_en=0, else high-Z.

Function
REQ-021 SHALL implement FSM states IDLE, WRITE, READ, TURN.
REQ-022 SHALL assert req_ready only in IDLE.
REQ-023 SHALL, on request accept, latch addr/len/op and enter WRITE or READ next cycle.
REQ-024 SHALL, in WRITE, assert wd_ready; on each handshake drive mem_wr=1, mem_en=0, mem_add=current addr, mem_d=wd_data in that same cycle.
REQ-025 SHALL, in WRITE with wd_valid=0, stall: mem_wr=0, mem_d high-Z, address and count held.
REQ-026 SHALL, in READ, drive mem_en=1, mem_wr=0 for one beat per cycle, sample mem_d at the rising edge ending the beat, and present it on rd_data with rd_valid=1 the following cycle (latency 1).
REQ-027 SHALL assert rd_last with the rd_valid of beat number req_len.
REQ-028 SHALL increment address modulo 2^AW per beat (15 wraps to 0).
REQ-029 SHALL, after the final beat of any burst, spend exactly one cycle in TURN (mem_wr=mem_en=0, mem_d high-Z), then return to IDLE.
REQ-030 SHALL never assert mem_wr and mem_en in the same cycle.
REQ-031 SHALL treat req_len=2^AW-1 as a full 16-beat sweep.
REQ-032 SHALL ignore wd_valid outside WRITE (wd_ready=0).

Reset
REQ-033 SHALL, on rst high, immediately (asynchronously) set state IDLE, req_ready=0 while rst high, wd_ready=0, rd_valid=0, rd_last=0, rd_data=0, busy=0, mem_wr=0, mem_en=0, mem_add=0, mem_d high-Z.
REQ-034 SHALL abort an in-progress burst on reset with no further beats; RAM contents already written remain.
REQ-035 SHALL assert req_ready in the first cycle after rst deasserts.

Structure
REQ-036 SHALL take DW, AW defaults and the FSM state encoding from shared package spr_pkg.
REQ-037 SHALL place the tristate driver for mem_d in sub-module spr_bus_drv (inputs oe, dout; inout pad).

Verification
REQ-038 SHALL cover write burst addr=0 len=15 data=0x00..0x0F, then read addr=0 len=15 -> rd_data 0x00..0x0F in order, rd_last on 0x0F, one TURN cycle between bursts.
REQ-039 SHALL cover write addr=14 len=3 data A0,A1,A2,A3 -> mem_add 14,15,0,1; read-back addr=14 len=3 returns A0..A3.
REQ-040 SHALL cover wd_valid low for 3 cycles mid-burst -> mem_wr=0 and mem_d high-Z in those cycles, no address advance, data intact on read-back.
REQ-041 SHALL cover rst pulsed on beat 2 of an 8-beat read -> all outputs at reset values within the same cycle, no further rd_valid, req_ready=1 the cycle after release.
REQ-042 SHALL cover req_valid held high during an active burst -> not accepted until IDLE; assert mem_wr&mem_en never both 1 throughout all scenarios.
